// File: rtl/push_buffer.sv
// push_buffer: push-side elastic buffer.
// The producer writes words with put_i while full_o is low. The head word is
// pushed to the sink (put_o) whenever the buffer is non-empty and the sink's
// full_i is low. Storage is a circular array of 2^A words.
//
// Handshake: a word moves producer->buffer on a rising edge where
// put_i & !full_o, and buffer->sink on a rising edge where put_o is high
// (put_o already folds in !full_i). A put_i while full_o is high is dropped.
module push_buffer #(
  parameter int W = 8,
  parameter int A = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] in,
  input  logic         put_i,
  output logic         full_o,
  output logic [W-1:0] out,
  output logic         put_o,
  input  logic         full_i
);

  localparam int DEPTH = 1 << A;
  localparam logic [A:0] FULL_LEVEL = (A + 1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [A-1:0] wp;
  logic [A-1:0] rp;
  logic [A:0]   count;
  logic [A:0]   count_next;
  logic         wr;

  // Accept only while not full; the offer depends on registered occupancy,
  // so full_i reaches put_o combinationally but put_i never does.
  assign wr    = put_i & ~full_o;
  assign put_o = (count != '0) & ~full_i;
  assign out   = mem[rp];

  // Next occupancy: a write and a read in the same cycle cancel out.
  always_comb begin
    count_next = count;
    unique case ({wr, put_o})
      2'b10:   count_next = count + (A + 1)'(1);
      2'b01:   count_next = count - (A + 1)'(1);
      default: count_next = count;
    endcase
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clock) begin
    if (wr) begin
      mem[wp] <= in;
    end
  end

  // Pointers, occupancy and the registered full flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp     <= '0;
      rp     <= '0;
      count  <= '0;
      full_o <= 1'b0;
    end else begin
      if (wr) begin
        wp <= wp + A'(1);
      end
      if (put_o) begin
        rp <= rp + A'(1);
      end
      count  <= count_next;
      full_o <= (count_next == FULL_LEVEL);
    end
  end

endmodule

// File: tb/tb_push_buffer.sv
// tb_push_buffer: directed bench for push_buffer (W=8, A=2).
// Inputs change 1 time unit after the rising edge; outputs are checked
// 1 unit later, well away from the next edge. A queue model tracks the
// words the buffer should hold and predicts put_o, out and full_o.
module tb_push_buffer;

  localparam int W = 8;
  localparam int A = 2;
  localparam int DEPTH = 1 << A;

  logic         clock;
  logic         reset;
  logic [W-1:0] in;
  logic         put_i;
  logic         full_o;
  logic [W-1:0] out;
  logic         put_o;
  logic         full_i;

  logic [W-1:0] exp_q[$];
  int           n_assert;
  int           n_fail;

  push_buffer #(.W(W), .A(A)) dut (
    .clock  (clock),
    .reset  (reset),
    .in     (in),
    .put_i  (put_i),
    .full_o (full_o),
    .out    (out),
    .put_o  (put_o),
    .full_i (full_i)
  );

  // Clock: 10-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, update the model,
  // then advance to just after the next rising edge.
  task automatic step(input string tag);
    logic         exp_put;
    logic         accept;
    logic [W-1:0] head;
    #1;
    exp_put = (exp_q.size() != 0) && !full_i;
    accept  = put_i && (exp_q.size() < DEPTH);
    check({tag, " full_o"}, full_o, exp_q.size() == DEPTH);
    check({tag, " put_o"}, put_o, exp_put);
    if (exp_put) begin
      head = exp_q.pop_front();
      check({tag, " out"}, out, head);
    end
    if (accept) exp_q.push_back(in);
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input string tag, input logic [W-1:0] d);
    put_i = 1'b1;
    in    = d;
    step(tag);
    put_i = 1'b0;
  endtask

  initial begin
    logic [W-1:0] hello [5];
    logic [W-1:0] pat;
    n_assert = 0;
    n_fail   = 0;
    hello[0] = 8'h68; hello[1] = 8'h65; hello[2] = 8'h6C;
    hello[3] = 8'h6C; hello[4] = 8'h6F;

    // Reset state before any edge.
    reset  = 1'b1;
    put_i  = 1'b0;
    in     = '0;
    full_i = 1'b0;
    #2;
    check("reset put_o", put_o, 1'b0);
    check("reset full_o", full_o, 1'b0);
    check("reset count", dut.count, 3'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step("idle");

    // Latency: one word, offered in the following cycle only.
    push_word("lat push", 8'h48);
    #1;
    check("lat put_o", put_o, 1'b1);
    check("lat out", out, 8'h48);
    step("lat offer");
    step("lat after");

    // "hello" streamed back to back.
    for (int i = 0; i < 5; i++) begin
      put_i = 1'b1;
      in    = hello[i];
      step("hello");
    end
    put_i = 1'b0;
    for (int i = 0; i < 3; i++) step("hello drain");

    // Fill with sink stalled, then a dropped fifth put.
    full_i = 1'b1;
    push_word("fill", 8'hA1);
    push_word("fill", 8'hA2);
    push_word("fill", 8'hA3);
    push_word("fill", 8'hA4);
    check("fill full_o", full_o, 1'b1);
    push_word("fill extra", 8'hEE);
    check("fill count", dut.count, 3'd4);
    full_i = 1'b0;
    step("drain first");
    check("drain full_o low", full_o, 1'b0);
    for (int i = 0; i < 4; i++) step("drain");
    check("drain empty", dut.count, 3'd0);

    // Steady state at occupancy 2.
    full_i = 1'b1;
    push_word("steady pre", 8'h00);
    push_word("steady pre", 8'h01);
    full_i = 1'b0;
    put_i  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pat = W'(i + 2);
      in  = pat;
      step("steady");
      check("steady count", dut.count, 3'd2);
    end
    put_i = 1'b0;
    for (int i = 0; i < 3; i++) step("steady drain");

    // Wrap-around: three fill/drain rounds.
    for (int r = 0; r < 3; r++) begin
      full_i = 1'b1;
      for (int i = 0; i < 4; i++) push_word("wrap fill", W'(8'h10 * (r + 1) + i));
      check("wrap full_o", full_o, 1'b1);
      full_i = 1'b0;
      for (int i = 0; i < 5; i++) step("wrap drain");
    end

    // Reset mid-operation with three words buffered.
    full_i = 1'b1;
    push_word("rst fill", 8'hC1);
    push_word("rst fill", 8'hC2);
    push_word("rst fill", 8'hC3);
    full_i = 1'b0;
    #1;
    check("pre-rst put_o", put_o, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst put_o", put_o, 1'b0);
    check("midrst full_o", full_o, 1'b0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    push_word("post-rst push", 8'hA5);
    #1;
    check("post-rst out", out, 8'hA5);
    step("post-rst offer");
    step("post-rst idle");

    // Random traffic with random sink back-pressure.
    for (int i = 0; i < 500; i++) begin
      put_i  = ($urandom_range(0, 1) == 1) && !full_o;
      in     = W'($urandom_range(0, 255));
      full_i = ($urandom_range(0, 2) == 0);
      step("rand");
      check("rand count bound", dut.count <= 3'd4, 1'b1);
    end
    put_i  = 1'b0;
    full_i = 1'b0;
    for (int i = 0; i < 6; i++) step("rand drain");
    check("rand model empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
